// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory controller:
// funct3 width codes, completion error codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_MISAL   = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Execute-side load/store handshake and data-memory
// req/gnt/rvalid port bundles.
interface lsu_ls_if;
    logic        ls_valid;
    logic        ls_ready;
    logic        ls_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [1:0]  ls_err;
    logic [31:0] ls_rdata;

    modport master (
        output ls_valid, ls_store, ls_funct3, ls_addr, ls_wdata,
        input  ls_ready, ls_done, ls_err, ls_rdata
    );
    modport slave (
        input  ls_valid, ls_store, ls_funct3, ls_addr, ls_wdata,
        output ls_ready, ls_done, ls_err, ls_rdata
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension,
// and width/alignment legality checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misal_o,
    output logic        illegal_o
);
    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        wstrb_o   = 4'b0000;
        wdata_o   = 32'h0;
        ldata_o   = 32'h0;
        misal_o   = 1'b0;
        illegal_o = 1'b0;
        unique case (funct3_i)
            F3_B: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                wstrb_o = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = {{16{shifted[15]}}, shifted[15:0]};
                misal_o = off_i[0];
            end
            F3_W: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                ldata_o = rdata_i;
                misal_o = |off_i;
            end
            // Unsigned widths exist only for loads
            F3_BU: begin
                ldata_o   = {24'h0, shifted[7:0]};
                illegal_o = store_i;
            end
            F3_HU: begin
                ldata_o   = {16'h0, shifted[15:0]};
                misal_o   = off_i[0];
                illegal_o = store_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// One data-memory access per load/store: alignment check,
// req/gnt/rvalid sequencing with timeout, registered result.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_ls_if.slave   ls,
    lsu_mem_if.master mem
);
    state_e      state_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;
    logic        done_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic        idle;
    logic        tmo;
    logic        al_store;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_misal;
    logic        al_illegal;

    assign idle = (state_q == IDLE);
    assign tmo  = (cnt_q == 8'(MEM_TIMEOUT - 1));

    // Checks use live inputs at accept; extraction uses the captured access
    assign al_store = idle ? ls.ls_store : store_q;
    assign al_f3    = idle ? ls.ls_funct3 : funct3_q;
    assign al_off   = idle ? ls.ls_addr[1:0] : off_q;

    lsu_align u_align (
        .store_i   (al_store),
        .funct3_i  (al_f3),
        .off_i     (al_off),
        .wdata_i   (ls.ls_wdata),
        .rdata_i   (mem.mem_rdata),
        .wstrb_o   (al_wstrb),
        .wdata_o   (al_wdata),
        .ldata_o   (al_ldata),
        .misal_o   (al_misal),
        .illegal_o (al_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
            err_q    <= ERR_OK;
            rdata_q  <= 32'h0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ls.ls_valid) begin
                        store_q  <= ls.ls_store;
                        funct3_q <= ls.ls_funct3;
                        off_q    <= ls.ls_addr[1:0];
                        addr_q   <= {ls.ls_addr[31:2], 2'b00};
                        we_q     <= ls.ls_store;
                        wstrb_q  <= al_wstrb;
                        wdata_q  <= al_wdata;
                        cnt_q    <= 8'd0;
                        if (al_illegal || al_misal) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= al_illegal ? ERR_ILLEGAL : ERR_MISAL;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem.mem_gnt) begin
                        req_q <= 1'b0;
                        if (store_q || mem.mem_rvalid) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= ERR_OK;
                            rdata_q <= store_q ? 32'h0 : al_ldata;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (tmo) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= ERR_TIMEOUT;
                        rdata_q <= 32'h0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem.mem_rvalid) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= ERR_OK;
                        rdata_q <= al_ldata;
                    end else if (tmo) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= ERR_TIMEOUT;
                        rdata_q <= 32'h0;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign ls.ls_ready  = idle;
    assign ls.ls_done   = done_q;
    assign ls.ls_err    = err_q;
    assign ls.ls_rdata  = rdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed cases, a
// randomized sweep, timeout and mid-access reset.
module tb_lsu_mem_ctrl;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    lsu_ls_if  ls ();
    lsu_mem_if mem ();

    lsu_mem_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ls    (ls),
        .mem   (mem)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t sb[$];

    // Memory responder knobs
    logic        gnt_en   = 1'b1;
    int          gnt_dly  = 0;
    int          rv_dly   = 0;
    logic [31:0] rsp_data = 32'h0;
    int          req_seen = 0;
    int          req_cycles = 0;
    logic        rv_pend  = 1'b0;
    int          rv_wait  = 0;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb;
    logic        g_we;

    // Completion monitor state
    logic done_seen = 1'b0;
    int   done_cyc  = 0;
    int   ndone     = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] mdl_err(input logic st,
            input logic [2:0] f3, input logic [1:0] o);
        logic ill, mis;
        ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = (f3[1:0] == 2'd1 && o[0]) || (f3 == 3'd2 && o != 2'd0);
        if (ill) return 2'd2;
        if (mis) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3,
            input logic [1:0] o, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd4: return {24'h0, b};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] mdl_strb(input logic [2:0] f3,
            input logic [1:0] o);
        logic [3:0] s;
        case (f3)
            3'd0: s = 4'b0001;
            3'd1: s = 4'b0011;
            default: s = 4'b1111;
        endcase
        if (f3 != 3'd2) s = s << o;
        return s;
    endfunction

    function automatic logic [31:0] mdl_wd(input logic [2:0] f3,
            input logic [31:0] w);
        case (f3)
            3'd0: return {w[7:0], w[7:0], w[7:0], w[7:0]};
            3'd1: return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            mem.mem_gnt    = 1'b0;
            mem.mem_rvalid = 1'b0;
            if (rv_pend) begin
                if (rv_wait == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = rsp_data;
                    rv_pend = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            if (mem.mem_req) begin
                req_cycles++;
                if (gnt_en && req_seen == gnt_dly) begin
                    mem.mem_gnt = 1'b1;
                    g_addr  = mem.mem_addr;
                    g_we    = mem.mem_we;
                    g_wstrb = mem.mem_wstrb;
                    g_wdata = mem.mem_wdata;
                    req_seen = 0;
                    if (!mem.mem_we) begin
                        if (rv_dly == 0) begin
                            mem.mem_rvalid = 1'b1;
                            mem.mem_rdata  = rsp_data;
                        end else begin
                            rv_pend = 1'b1;
                            rv_wait = rv_dly - 1;
                        end
                    end
                end else begin
                    req_seen++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (ls.ls_done === 1'b1) begin
            ndone++;
            done_seen = 1'b1;
            done_cyc  = cyc;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(ls.ls_done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ls_err", 32'(ls.ls_err), 32'(e.err));
                chk("ls_rdata", ls.ls_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3,
            input logic [31:0] a, input logic [31:0] wd,
            input logic [1:0] e, input logic [31:0] r, input int lat);
        int n;
        int acc;
        n = 0;
        while (ls.ls_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        done_seen  = 1'b0;
        req_cycles = 0;
        req_seen   = 0;
        ls.ls_valid  = 1'b1;
        ls.ls_store  = st;
        ls.ls_funct3 = f3;
        ls.ls_addr   = a;
        ls.ls_wdata  = wd;
        acc = cyc + 1;
        sb.push_back('{err: e, rdata: r});
        @(negedge clk);
        ls.ls_valid = 1'b0;
        #1;
        n = 0;
        while (!done_seen && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!done_seen) begin
            chk("done_wait", 32'd0, 32'd1);
            sb.delete();
        end else begin
            chk("latency", 32'(done_cyc - acc), 32'(lat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, er;
        logic [1:0]  e;
        int          nd0;

        rst_n        = 1'b0;
        ls.ls_valid  = 1'b0;
        ls.ls_store  = 1'b0;
        ls.ls_funct3 = 3'd0;
        ls.ls_addr   = 32'h0;
        ls.ls_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ls.ls_ready), 32'd1);
        chk("rst_done", 32'(ls.ls_done), 32'd0);
        chk("rst_req", 32'(mem.mem_req), 32'd0);
        chk("rst_addr", mem.mem_addr, 32'h0);
        chk("rst_wstrb", 32'(mem.mem_wstrb), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        gnt_en = 1'b1; gnt_dly = 0; rv_dly = 0;
        issue(1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 2'd0, 32'h0, 1);
        chk("sb_addr", g_addr, 32'h0000_1000);
        chk("sb_we", 32'(g_we), 32'd1);
        chk("sb_wstrb", 32'(g_wstrb), 32'h8);
        chk("sb_wdata", g_wdata, 32'hDDDD_DDDD);

        rsp_data = 32'h0080_7F00; rv_dly = 3;
        issue(1'b0, 3'd0, 32'h0000_2002, 32'h0, 2'd0, 32'hFFFF_FF80, 4);
        chk("lb_addr", g_addr, 32'h0000_2000);
        chk("lb_we", 32'(g_we), 32'd0);
        issue(1'b0, 3'd4, 32'h0000_2002, 32'h0, 2'd0, 32'h0000_0080, 4);
        issue(1'b0, 3'd5, 32'h0000_2002, 32'h0, 2'd0, 32'h0000_0080, 4);
        issue(1'b0, 3'd2, 32'h0000_2000, 32'h0, 2'd0, 32'h0080_7F00, 4);

        issue(1'b0, 3'd2, 32'h0000_2001, 32'h0, 2'd1, 32'h0, 0);
        chk("misal_lw_noreq", 32'(req_cycles), 32'd0);
        issue(1'b1, 3'd1, 32'h0000_3003, 32'h1234, 2'd1, 32'h0, 0);
        chk("misal_sh_noreq", 32'(req_cycles), 32'd0);
        issue(1'b1, 3'd3, 32'h0000_3000, 32'h1234, 2'd2, 32'h0, 0);
        issue(1'b0, 3'd7, 32'h0000_3001, 32'h0, 2'd2, 32'h0, 0);

        rsp_data = 32'h0000_FFFE; rv_dly = 0;
        issue(1'b0, 3'd1, 32'h0000_0000, 32'h0, 2'd0, 32'hFFFF_FFFE, 1);

        gnt_dly = 2;
        issue(1'b1, 3'd2, 32'h0000_0040, 32'h1234_5678, 2'd0, 32'h0, 3);
        chk("sw_wstrb", 32'(g_wstrb), 32'hF);
        chk("sw_wdata", g_wdata, 32'h1234_5678);
        gnt_dly = 0;
        issue(1'b1, 3'd1, 32'h0000_0042, 32'h1234_ABCD, 2'd0, 32'h0, 1);
        chk("sh_wstrb", 32'(g_wstrb), 32'hC);
        chk("sh_wdata", g_wdata, 32'hABCD_ABCD);

        for (int i = 0; i < 24; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom();
            wd = $urandom();
            rd = $urandom();
            gnt_dly  = $urandom_range(0, 2);
            rv_dly   = $urandom_range(0, 2);
            rsp_data = rd;
            e  = mdl_err(st, f3, a[1:0]);
            er = (e != 2'd0 || st) ? 32'h0 : mdl_load(f3, a[1:0], rd);
            issue(st, f3, a, wd, e, er,
                  (e != 2'd0) ? 0 : (st ? 1 + gnt_dly : 1 + gnt_dly + rv_dly));
            if (e == 2'd0) begin
                chk("rnd_addr", g_addr, {a[31:2], 2'b00});
                chk("rnd_we", 32'(g_we), 32'(st));
                if (st) begin
                    chk("rnd_wstrb", 32'(g_wstrb), 32'(mdl_strb(f3, a[1:0])));
                    chk("rnd_wdata", g_wdata, mdl_wd(f3, wd));
                end
            end else begin
                chk("rnd_err_noreq", 32'(req_cycles), 32'd0);
            end
        end

        gnt_en = 1'b0; gnt_dly = 0; rv_dly = 0;
        issue(1'b0, 3'd2, 32'h0000_5000, 32'h0, 2'd3, 32'h0, 16);
        chk("tmo_req_cycles", 32'(req_cycles), 32'd16);
        chk("tmo_req_low", 32'(mem.mem_req), 32'd0);
        nd0 = ndone;
        rsp_data = 32'hDEAD_BEEF;
        rv_pend  = 1'b1;
        rv_wait  = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("late_rv_ignored", 32'(ndone), 32'(nd0));

        gnt_en = 1'b1; gnt_dly = 0; rv_dly = 6;
        rsp_data = 32'h1234_5678;
        req_seen = 0;
        nd0 = ndone;
        ls.ls_valid  = 1'b1;
        ls.ls_store  = 1'b0;
        ls.ls_funct3 = 3'd2;
        ls.ls_addr   = 32'h0000_2000;
        @(negedge clk);
        ls.ls_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wait_busy", 32'(ls.ls_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("wrst_ready", 32'(ls.ls_ready), 32'd1);
        chk("wrst_done", 32'(ls.ls_done), 32'd0);
        chk("wrst_err", 32'(ls.ls_err), 32'd0);
        chk("wrst_rdata", ls.ls_rdata, 32'h0);
        chk("wrst_req", 32'(mem.mem_req), 32'd0);
        chk("wrst_addr", mem.mem_addr, 32'h0);
        chk("wrst_wdata", mem.mem_wdata, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("wrst_rv_ignored", 32'(ndone), 32'(nd0));

        rv_dly = 1;
        rsp_data = 32'hCAFE_F00D;
        issue(1'b0, 3'd2, 32'h0000_2000, 32'h0, 2'd0, 32'hCAFE_F00D, 2);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
